// File: rtl/simd_lane_feeder.sv
// simd_lane_feeder: activation FIFO plus double-buffered weight tile for one SIMD lane.
// Activations are issued one per cycle while the active tile is valid. A new tile is
// staged in the shadow bank and swapped in only after the lane pipeline has drained.
module simd_lane_feeder #(
   parameter int DEPTH    = 4,
   parameter int LANE_LAT = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [63:0]             s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [63:0]             w_data,
   input  logic [2:0]              w_idx,
   input  logic                    w_valid,
   input  logic                    w_commit,
   output logic                    w_ready,
   output logic [63:0]             o_lane_data,
   output logic                    o_lane_data_v,
   output logic [511:0]            o_lane_weight,
   output logic [$clog2(DEPTH):0]  o_fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = (LANE_LAT < 2) ? 1 : $clog2(LANE_LAT + 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_SWAP
   } state_t;

   state_t           state;
   logic [DW-1:0]    drain_cnt;
   logic             act_valid;
   logic [63:0]      fifo_mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [7:0][63:0] shadow;
   logic [7:0][63:0] active;
   logic             push;
   logic             pop;
   logic             w_wr;

   // Ready depends only on the registered count, so a full FIFO never accepts even on a pop cycle.
   assign s_ready       = (o_fifo_count != CW'(DEPTH));
   assign w_ready       = (state == ST_RUN);
   assign push          = s_valid & s_ready;
   assign pop           = (o_fifo_count != '0) & act_valid & (state == ST_RUN);
   assign w_wr          = w_valid & w_ready;
   assign o_lane_weight = active;

   // FIFO storage; contents need no reset because the count qualifies every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= s_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   o_fifo_count <= o_fifo_count + CW'(1);
            2'b01:   o_fifo_count <= o_fifo_count - CW'(1);
            default: o_fifo_count <= o_fifo_count;
         endcase
      end
   end

   // Registered issue stage: the popped head goes to the lane, data holds when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_lane_data   <= '0;
         o_lane_data_v <= 1'b0;
      end else begin
         o_lane_data_v <= pop;
         if (pop) begin
            o_lane_data <= fifo_mem[rd_ptr];
         end
      end
   end

   // Shadow bank row writes, accepted only in RUN so a tile cannot change mid-swap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow <= '0;
      end else if (w_wr) begin
         shadow[w_idx] <= w_data;
      end
   end

   // Commit sequencer: drain the lane pipeline, then copy shadow into the active bank.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
         act_valid <= 1'b0;
         active    <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (w_commit) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DW'(LANE_LAT);
               end
            end
            ST_DRAIN: begin
               drain_cnt <= drain_cnt - DW'(1);
               if (drain_cnt == DW'(1)) begin
                  state <= ST_SWAP;
               end
            end
            ST_SWAP: begin
               active    <= shadow;
               act_valid <= 1'b1;
               state     <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simd_lane_feeder.sv
// tb_simd_lane_feeder: directed vectors with hand-computed expectations for the lane feeder.
// A small queue tracks accepted beats so issue order, loss and duplication are all visible.
module tb_simd_lane_feeder;

   logic          clk;
   logic          rst;
   logic [63:0]   sData;
   logic          sValid;
   logic          sReady;
   logic [63:0]   wData;
   logic [2:0]    wIdx;
   logic          wValid;
   logic          wCommit;
   logic          wReady;
   logic [63:0]   laneData;
   logic          laneDataV;
   logic [511:0]  laneWeight;
   logic [2:0]    fifoCount;

   int            comparedCount = 0;
   int            mismatchCount = 0;
   logic [63:0]   expQ [$];
   logic [63:0]   nextBeat;
   logic [7:0][63:0] expShadow;
   logic [7:0][63:0] expActive;

   simd_lane_feeder #(
      .DEPTH    (4),
      .LANE_LAT (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_data        (sData),
      .s_valid       (sValid),
      .s_ready       (sReady),
      .w_data        (wData),
      .w_idx         (wIdx),
      .w_valid       (wValid),
      .w_commit      (wCommit),
      .w_ready       (wReady),
      .o_lane_data   (laneData),
      .o_lane_data_v (laneDataV),
      .o_lane_weight (laneWeight),
      .o_fifo_count  (fifoCount)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Safety net so the run always ends even if something stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      comparedCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, let the edge pass, then return 1 ns after it
   task automatic applyStimulus(input logic sv, input logic [63:0] sd, input logic wv,
                                input logic [2:0] wi, input logic [63:0] wd, input logic wc);
      sValid  = sv;
      sData   = sd;
      wValid  = wv;
      wIdx    = wi;
      wData   = wd;
      wCommit = wc;
      @(posedge clk);
      #1;
      sValid  = 1'b0;
      wValid  = 1'b0;
      wCommit = 1'b0;
   endtask

   // One streaming cycle: check ready, push into the model if accepted, then check issue
   task automatic streamCycle(input logic push, input logic expReady, input logic commit,
                              input logic wv, input logic [2:0] wi, input logic [63:0] wd,
                              input logic expV);
      logic [63:0] expData;
      checkOutput("s_ready", 512'(sReady), 512'(expReady));
      if (push && expReady) expQ.push_back(nextBeat);
      applyStimulus(push, nextBeat, wv, wi, wd, commit);
      if (push && expReady) nextBeat = nextBeat + 64'h1;
      checkOutput("lane_data_v", 512'(laneDataV), 512'(expV));
      if (expV) begin
         checkOutput("scoreboard_nonempty", 512'(expQ.size() != 0), 512'(1'b1));
         if (expQ.size() != 0) begin
            expData = expQ.pop_front();
            checkOutput("lane_data", 512'(laneData), 512'(expData));
         end
      end
   endtask

   // Pulse reset across one edge and clear the bench model
   task automatic doReset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      expQ.delete();
      expShadow = '0;
      expActive = '0;
   endtask

   // Directed sequence covering reset, backpressure, tile commit timing and mid-drain reset
   initial begin
      clk = 1'b0; rst = 1'b0;
      sValid = 1'b0; sData = '0; wValid = 1'b0; wIdx = '0; wData = '0; wCommit = 1'b0;
      nextBeat  = 64'h00A0_0000_0000_0000;
      expShadow = '0;
      expActive = '0;

      // Reset is asynchronous: state is clear before any clock edge
      #1;
      checkOutput("reset_count", 512'(fifoCount), 512'(3'd0));
      checkOutput("reset_data_v", 512'(laneDataV), 512'(1'b0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("post_reset_s_ready", 512'(sReady), 512'(1'b1));
      checkOutput("post_reset_w_ready", 512'(wReady), 512'(1'b1));
      checkOutput("post_reset_data", 512'(laneData), 512'(64'h0));
      checkOutput("post_reset_weight", laneWeight, 512'(0));

      // No commit yet: four beats fill the FIFO, nothing issues, then backpressure
      for (int n = 0; n < 6; n++) streamCycle(1'b1, (n < 4), 1'b0, 1'b0, 3'd0, 64'h0, 1'b0);
      checkOutput("full_count", 512'(fifoCount), 512'(3'd4));
      checkOutput("full_s_ready", 512'(sReady), 512'(1'b0));
      doReset();

      // Load rows 0..7 with 0x0101..*(i+1), commit, and watch the swap land three edges later
      for (int i = 0; i < 8; i++) begin
         expShadow[i] = {8{8'(i + 1)}};
         applyStimulus(1'b0, 64'h0, 1'b1, 3'(i), expShadow[i], 1'b0);
      end
      applyStimulus(1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 1'b1);
      checkOutput("drain_w_ready", 512'(wReady), 512'(1'b0));
      applyStimulus(1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 1'b0);
      applyStimulus(1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 1'b0);
      checkOutput("weight_before_swap", laneWeight, 512'(0));
      applyStimulus(1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 1'b0);
      expActive = expShadow;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("weight_row%0d", i), 512'(laneWeight[i*64 +: 64]), 512'(expActive[i]));
      end

      // Ten back-to-back beats: each issues one cycle after acceptance, in order
      for (int n = 0; n < 10; n++) streamCycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, (n != 0));
      streamCycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b1);
      streamCycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0);

      // Commit while streaming: three silent cycles, swap on the third, resume after
      expShadow[0] = 64'h1111_1111_1111_1111;
      applyStimulus(1'b0, 64'h0, 1'b1, 3'd0, expShadow[0], 1'b0);
      for (int n = 0; n < 12; n++) begin
         streamCycle(1'b1, (n != 7), (n == 3), 1'b0, 3'd0, 64'h0,
                     ((n >= 1) && (n <= 3)) || (n >= 7));
         if (n == 5) checkOutput("stream_weight_old", laneWeight, expActive);
         if (n == 6) begin
            expActive = expShadow;
            checkOutput("stream_weight_new", laneWeight, expActive);
         end
      end
      for (int k = 0; k < 4; k++) streamCycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, (k < 3));
      checkOutput("stream_drained_count", 512'(fifoCount), 512'(3'd0));

      // Same-cycle row write and commit from empty; FIFO fills during drain then trades 1:1
      expShadow[3] = 64'hDEAD_BEEF_0000_0001;
      for (int n = 0; n < 9; n++) begin
         streamCycle(1'b1, (n != 4), (n == 0) || (n == 8), (n == 0), 3'd3,
                     64'hDEAD_BEEF_0000_0001, (n >= 4));
         if (n == 2) checkOutput("same_cycle_weight_old", laneWeight, expActive);
         if (n == 3) begin
            expActive = expShadow;
            checkOutput("same_cycle_row3", 512'(laneWeight[3*64 +: 64]), 512'(64'hDEAD_BEEF_0000_0001));
            checkOutput("same_cycle_weight_new", laneWeight, expActive);
            checkOutput("fill_during_drain_count", 512'(fifoCount), 512'(3'd4));
         end
      end
      checkOutput("mid_drain_count", 512'(fifoCount), 512'(3'd3));
      checkOutput("mid_drain_w_ready", 512'(wReady), 512'(1'b0));

      // Reset mid-drain with three beats buffered: everything clears without a clock edge
      rst = 1'b0;
      #1;
      checkOutput("async_reset_data", 512'(laneData), 512'(64'h0));
      checkOutput("async_reset_data_v", 512'(laneDataV), 512'(1'b0));
      checkOutput("async_reset_count", 512'(fifoCount), 512'(3'd0));
      checkOutput("async_reset_weight", laneWeight, 512'(0));
      checkOutput("async_reset_w_ready", 512'(wReady), 512'(1'b1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      expQ.delete();
      expShadow = '0;
      expActive = '0;

      // The lost commit must not resurface: new beats sit in the FIFO unissued
      streamCycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0);
      streamCycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0);
      for (int k = 0; k < 4; k++) streamCycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, 1'b0);
      checkOutput("after_reset_count", 512'(fifoCount), 512'(3'd2));
      checkOutput("after_reset_weight", laneWeight, 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparedCount, mismatchCount);
      $finish;
   end

endmodule
